// File: rtl/ycbcr_pkg.sv
// Shared types and constants for the YCbCr stream scheduler and its result FIFO.
package ycbcr_pkg;

    localparam int PIXELS_PER_BLOCK = 64;
    localparam int IDX_W            = 6;
    localparam int FP_LEN           = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef struct packed {
        logic [FP_LEN-1:0] y;
        logic [FP_LEN-1:0] cb;
        logic [FP_LEN-1:0] cr;
        logic [IDX_W-1:0]  idx;
        logic              blk_last;
        logic              frame_last;
    } fifo_entry_t;

endpackage

// File: rtl/ycbcr_result_fifo.sv
// Circular result FIFO holding converted pixels with their block-position tags.
module ycbcr_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Gating the head on empty keeps outputs at zero after reset without resetting the array.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = do_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_o));

endmodule

// File: rtl/ycbcr_stream_scheduler.sv
// Schedules an RGB stream through the external one-register YCbCr converter and
// buffers tagged results for the DCT stage; credit logic guarantees no result is dropped.
//
// state    | meaning
// ST_IDLE  | waiting for start
// ST_RUN   | accepting pixels until the frame count reaches zero
// ST_FLUSH | all pixels accepted, draining in-flight result and FIFO
// ST_DONE  | one-cycle done pulse
module ycbcr_stream_scheduler
    import ycbcr_pkg::*;
#(
    parameter int INPUT_WIDTH        = 8,
    parameter int FIXED_POINT_LENGTH = FP_LEN,
    parameter int FIFO_DEPTH         = 4,
    parameter int BLK_CNT_W          = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [BLK_CNT_W-1:0]          cfg_num_blocks,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [INPUT_WIDTH-1:0]        s_r,
    input  logic [INPUT_WIDTH-1:0]        s_g,
    input  logic [INPUT_WIDTH-1:0]        s_b,
    output logic [INPUT_WIDTH-1:0]        conv_r,
    output logic [INPUT_WIDTH-1:0]        conv_g,
    output logic [INPUT_WIDTH-1:0]        conv_b,
    input  logic [FIXED_POINT_LENGTH-1:0] conv_y,
    input  logic [FIXED_POINT_LENGTH-1:0] conv_cb,
    input  logic [FIXED_POINT_LENGTH-1:0] conv_cr,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [FIXED_POINT_LENGTH-1:0] m_y,
    output logic [FIXED_POINT_LENGTH-1:0] m_cb,
    output logic [FIXED_POINT_LENGTH-1:0] m_cr,
    output logic [IDX_W-1:0]              m_idx,
    output logic                          m_blk_last,
    output logic                          m_frame_last,
    output logic                          busy,
    output logic                          done
);

    localparam int PL_W  = BLK_CNT_W + IDX_W;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    state_e           state_q, state_d;
    logic [PL_W-1:0]  pixels_left_q, pixels_left_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             inflight_q, inflight_d;
    logic [IDX_W-1:0] tag_idx_q, tag_idx_d;
    logic             tag_blk_last_q, tag_blk_last_d;
    logic             tag_frame_last_q, tag_frame_last_d;

    logic             accept;
    logic             credit_ok;
    fifo_entry_t      wr_entry;
    fifo_entry_t      rd_entry;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    assign conv_r = s_r;
    assign conv_g = s_g;
    assign conv_b = s_b;

    // Credit counts the converter register as occupied so its result always has a slot.
    assign credit_ok = (32'(fifo_count) + 32'(inflight_q)) < 32'(FIFO_DEPTH);
    assign accept    = s_valid && s_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = (cfg_num_blocks == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (accept && pixels_left_q == PL_W'(1)) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (!inflight_q && fifo_empty) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_ready = (state_q == ST_RUN) && (pixels_left_q != '0) && credit_ok && !fifo_full;
        busy    = (state_q != ST_IDLE);
        done    = (state_q == ST_DONE);
    end

    always_comb begin
        pixels_left_d    = pixels_left_q;
        idx_d            = idx_q;
        inflight_d       = 1'b0;
        tag_idx_d        = tag_idx_q;
        tag_blk_last_d   = tag_blk_last_q;
        tag_frame_last_d = tag_frame_last_q;
        if (state_q == ST_IDLE && start) begin
            pixels_left_d = {cfg_num_blocks, {IDX_W{1'b0}}};
            idx_d         = '0;
        end
        if (accept) begin
            inflight_d       = 1'b1;
            tag_idx_d        = idx_q;
            tag_blk_last_d   = (idx_q == IDX_W'(PIXELS_PER_BLOCK - 1));
            tag_frame_last_d = (pixels_left_q == PL_W'(1));
            idx_d            = idx_q + IDX_W'(1);
            pixels_left_d    = pixels_left_q - PL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pixels_left_q    <= '0;
            idx_q            <= '0;
            inflight_q       <= 1'b0;
            tag_idx_q        <= '0;
            tag_blk_last_q   <= 1'b0;
            tag_frame_last_q <= 1'b0;
        end else begin
            pixels_left_q    <= pixels_left_d;
            idx_q            <= idx_d;
            inflight_q       <= inflight_d;
            tag_idx_q        <= tag_idx_d;
            tag_blk_last_q   <= tag_blk_last_d;
            tag_frame_last_q <= tag_frame_last_d;
        end
    end

    always_comb begin
        wr_entry            = '0;
        wr_entry.y          = conv_y;
        wr_entry.cb         = conv_cb;
        wr_entry.cr         = conv_cr;
        wr_entry.idx        = tag_idx_q;
        wr_entry.blk_last   = tag_blk_last_q;
        wr_entry.frame_last = tag_frame_last_q;
    end

    ycbcr_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fifo_entry_t)),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (inflight_q),
        .pop_i   (m_ready),
        .wdata_i (wr_entry),
        .rdata_o (rd_entry),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign m_valid      = !fifo_empty;
    assign m_y          = rd_entry.y;
    assign m_cb         = rd_entry.cb;
    assign m_cr         = rd_entry.cr;
    assign m_idx        = rd_entry.idx;
    assign m_blk_last   = rd_entry.blk_last;
    assign m_frame_last = rd_entry.frame_last;

endmodule

// File: tb/tb_ycbcr_stream_scheduler.sv
// Self-checking bench: models the external converter, scoreboards every accepted pixel.
module tb_ycbcr_stream_scheduler;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] cfg_num_blocks;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_r, s_g, s_b;
    logic [7:0]  conv_r, conv_g, conv_b;
    logic [31:0] conv_y, conv_cb, conv_cr;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_y, m_cb, m_cr;
    logic [5:0]  m_idx;
    logic        m_blk_last, m_frame_last;
    logic        busy, done;

    ycbcr_stream_scheduler dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_num_blocks(cfg_num_blocks),
        .s_valid(s_valid), .s_ready(s_ready), .s_r(s_r), .s_g(s_g), .s_b(s_b),
        .conv_r(conv_r), .conv_g(conv_g), .conv_b(conv_b),
        .conv_y(conv_y), .conv_cb(conv_cb), .conv_cr(conv_cr),
        .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y), .m_cb(m_cb), .m_cr(m_cr),
        .m_idx(m_idx), .m_blk_last(m_blk_last), .m_frame_last(m_frame_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] f_y(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int v;
        v = 313524 * int'(r) + 615514 * int'(g) + 119538 * int'(b);
        return 32'(v);
    endfunction
    function automatic logic [31:0] f_cb(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int v;
        v = -176933 * int'(r) - 347355 * int'(g) + 524288 * int'(b) + 134217728;
        return 32'(v);
    endfunction
    function automatic logic [31:0] f_cr(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        int v;
        v = 524288 * int'(r) - 439026 * int'(g) - 85262 * int'(b) + 134217728;
        return 32'(v);
    endfunction

    // External conversion unit: one register, no enable.
    always @(posedge clk) begin
        conv_y  <= f_y(conv_r, conv_g, conv_b);
        conv_cb <= f_cb(conv_r, conv_g, conv_b);
        conv_cr <= f_cr(conv_r, conv_g, conv_b);
    end

    typedef struct {
        logic [31:0] y, cb, cr;
        logic [5:0]  idx;
        logic        bl, fl;
    } exp_t;

    exp_t sb[$];
    int   n_asserts = 0;
    int   n_fail    = 0;
    int   cyc       = 0;

    logic [5:0]  exp_idx;
    int          exp_left, exp_total;
    bit          acc_last;
    int          acc_cnt, out_cnt, fl_cnt, bl_cnt, done_cnt, busy_cnt, sready_cnt;
    int          first_acc_cyc, first_mv_cyc, first_pop_cyc, last_pop_cyc, done_cyc, start_cyc;
    int          first_pop_idx;
    bit          red_first, red_seen, blocked_seen;
    logic [31:0] red_y;
    bit          stall_prev;
    logic [31:0] p_y, p_cb, p_cr;
    logic [5:0]  p_idx;
    logic        p_bl, p_fl;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        acc_last = 1'b0;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            if (sb.size() >= DEPTH) begin
                n_asserts++;
                if (s_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL credit_block: s_ready=%b required 0 with %0d outstanding", s_ready, sb.size());
                end
                if (!s_ready) blocked_seen = 1'b1;
            end else if (busy && !done && acc_cnt < exp_total) begin
                n_asserts++;
                if (s_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL credit_open: s_ready=%b required 1 with %0d outstanding", s_ready, sb.size());
                end
            end
            if (stall_prev) begin
                n_asserts++;
                if (m_valid !== 1'b1 || m_y !== p_y || m_cb !== p_cb || m_cr !== p_cr ||
                    m_idx !== p_idx || m_blk_last !== p_bl || m_frame_last !== p_fl) begin
                    n_fail++;
                    $display("FAIL stall_stable: got v=%b y=%h idx=%0d required v=1 y=%h idx=%0d",
                             m_valid, m_y, m_idx, p_y, p_idx);
                end
            end
            stall_prev = m_valid && !m_ready;
            p_y = m_y; p_cb = m_cb; p_cr = m_cr; p_idx = m_idx; p_bl = m_blk_last; p_fl = m_frame_last;
            if (m_valid && first_mv_cyc < 0) first_mv_cyc = cyc;
            if (s_ready) sready_cnt++;
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (m_valid && m_ready) begin
                n_asserts++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL pop_unexpected: got idx=%0d y=%h required no output", m_idx, m_y);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (m_y !== e.y || m_cb !== e.cb || m_cr !== e.cr || m_idx !== e.idx ||
                        m_blk_last !== e.bl || m_frame_last !== e.fl) begin
                        n_fail++;
                        $display("FAIL pop_data: got y=%h cb=%h cr=%h idx=%0d bl=%b fl=%b required y=%h cb=%h cr=%h idx=%0d bl=%b fl=%b",
                                 m_y, m_cb, m_cr, m_idx, m_blk_last, m_frame_last,
                                 e.y, e.cb, e.cr, e.idx, e.bl, e.fl);
                    end
                end
                if (first_pop_cyc < 0) begin
                    first_pop_cyc = cyc;
                    first_pop_idx = int'(m_idx);
                end
                if (red_first && out_cnt == 0) begin
                    red_y    = m_y;
                    red_seen = 1'b1;
                end
                last_pop_cyc = cyc;
                out_cnt++;
                if (m_frame_last) fl_cnt++;
                if (m_blk_last) bl_cnt++;
            end
            if (s_valid && s_ready) begin
                exp_t n;
                n.y  = f_y(s_r, s_g, s_b);
                n.cb = f_cb(s_r, s_g, s_b);
                n.cr = f_cr(s_r, s_g, s_b);
                n.idx = exp_idx;
                n.bl = (exp_idx == 6'd63);
                n.fl = (exp_left == 1);
                sb.push_back(n);
                exp_idx++;
                exp_left--;
                acc_last = 1'b1;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                acc_cnt++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int got, input int req);
        n_asserts++;
        if (got != req) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic clear_stats();
        acc_cnt = 0; out_cnt = 0; fl_cnt = 0; bl_cnt = 0; done_cnt = 0; busy_cnt = 0; sready_cnt = 0;
        first_acc_cyc = -1; first_mv_cyc = -1; first_pop_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
        first_pop_idx = -1; red_seen = 1'b0; blocked_seen = 1'b0;
    endtask

    task automatic begin_frame(input int nblk);
        clear_stats();
        exp_idx   = 6'd0;
        exp_left  = nblk * 64;
        exp_total = nblk * 64;
        start_cyc = cyc;
        start = 1'b1;
        cfg_num_blocks = 16'(nblk);
        tick();
        start = 1'b0;
    endtask

    task automatic run_frame(input int nblk, input int pv, input int pr, input int budget,
                             input int pulse_at, input int stall_at);
        int stall_rem;
        bit timed_out;
        stall_rem = (stall_at >= 0) ? 10 : 0;
        s_valid = 1'b0;
        begin_frame(nblk);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != 0) begin
                timed_out = 1'b0;
                break;
            end
            if (!s_valid || acc_last) begin
                s_valid = ($urandom_range(99) < pv);
                if (red_first && acc_cnt == 0) begin
                    s_r = 8'd255; s_g = 8'd0; s_b = 8'd0;
                end else begin
                    s_r = 8'($urandom); s_g = 8'($urandom); s_b = 8'($urandom);
                end
            end
            if (stall_at >= 0 && out_cnt >= stall_at && stall_rem > 0) begin
                m_ready = 1'b0;
                stall_rem--;
            end else begin
                m_ready = ($urandom_range(99) < pr);
            end
            if (i == pulse_at) begin
                start = 1'b1;
                cfg_num_blocks = 16'd5;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        s_valid = 1'b0;
        start = 1'b0;
        n_asserts++;
        if (timed_out) begin
            n_fail++;
            $display("FAIL frame_timeout: got no done after %0d cycles required done", budget);
        end
        chk("scoreboard_drained", sb.size(), 0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; cfg_num_blocks = '0; s_valid = 1'b0; m_ready = 1'b0;
        s_r = '0; s_g = '0; s_b = '0;
        tick(); tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("reset_s_ready", int'(s_ready), 0);
        chk("reset_m_valid", int'(m_valid), 0);
        chk("reset_m_idx", int'(m_idx), 0);
        chk("reset_m_blk_last", int'(m_blk_last), 0);
        chk("reset_m_frame_last", int'(m_frame_last), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_m_y", int'(m_y | m_cb | m_cr), 0);
    endtask

    task automatic test_single_block();
        run_frame(1, 100, 100, 200, -1, -1);
        chk("single_outputs", out_cnt, 64);
        chk("single_latency", first_mv_cyc - first_acc_cyc, 2);
        chk("single_back_to_back", last_pop_cyc - first_pop_cyc, 63);
        chk("single_first_idx", first_pop_idx, 0);
        chk("single_frame_last_cnt", fl_cnt, 1);
        chk("single_blk_last_cnt", bl_cnt, 1);
        chk("single_done_cnt", done_cnt, 1);
        chk("single_done_after_pop", int'(done_cyc > last_pop_cyc), 1);
    endtask

    task automatic test_back_pressure();
        red_first = 1'b1;
        run_frame(2, 100, 100, 400, -1, 5);
        red_first = 1'b0;
        chk("bp_outputs", out_cnt, 128);
        chk("bp_blocked_seen", int'(blocked_seen), 1);
        chk("bp_red_seen", int'(red_seen), 1);
        n_asserts++;
        if (red_y !== 32'd79948620) begin
            n_fail++;
            $display("FAIL bp_red_y: got %0d required 79948620", red_y);
        end
        chk("bp_blk_last_cnt", bl_cnt, 2);
    endtask

    task automatic test_random();
        run_frame(3, 50, 50, 4000, -1, -1);
        chk("rand_outputs", out_cnt, 192);
        chk("rand_frame_last_cnt", fl_cnt, 1);
        chk("rand_blk_last_cnt", bl_cnt, 3);
        chk("rand_done_cnt", done_cnt, 1);
    endtask

    task automatic test_zero_blocks();
        s_valid = 1'b1; m_ready = 1'b1;
        begin_frame(0);
        for (int i = 0; i < 5; i++) tick();
        s_valid = 1'b0;
        chk("zero_done_cnt", done_cnt, 1);
        chk("zero_done_timing", done_cyc - start_cyc, 1);
        chk("zero_busy_cycles", busy_cnt, 1);
        chk("zero_s_ready_cycles", sready_cnt, 0);
        chk("zero_outputs", out_cnt, 0);
    endtask

    task automatic test_reset_midframe();
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_r = 8'd10; s_g = 8'd20; s_b = 8'd30;
        begin_frame(2);
        for (int i = 0; i < 20 && acc_cnt < 3; i++) begin
            if (acc_last) begin
                s_r = 8'($urandom); s_g = 8'($urandom); s_b = 8'($urandom);
            end
            tick();
        end
        s_valid = 1'b0;
        tick(); tick();
        chk("midrst_outstanding", sb.size(), 3);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        chk("midrst_m_valid", int'(m_valid), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_s_ready", int'(s_ready), 0);
        chk("midrst_done", int'(done), 0);
        tick();
        run_frame(1, 100, 100, 200, -1, -1);
        chk("midrst_outputs", out_cnt, 64);
        chk("midrst_first_idx", first_pop_idx, 0);
    endtask

    task automatic test_start_during_run();
        run_frame(1, 100, 70, 400, 20, -1);
        chk("startrun_accepts", acc_cnt, 64);
        chk("startrun_outputs", out_cnt, 64);
        chk("startrun_done_cnt", done_cnt, 1);
    endtask

    task automatic test_back_to_back();
        run_frame(1, 100, 100, 200, -1, -1);
        s_valid = 1'b0;
        begin_frame(1);
        n_asserts++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_restart_busy: got %b required 1", busy);
        end
        s_valid = 1'b1; m_ready = 1'b1;
        for (int i = 0; i < 200 && done_cnt == 0; i++) begin
            if (acc_last) begin
                s_r = 8'($urandom); s_g = 8'($urandom); s_b = 8'($urandom);
            end
            tick();
        end
        s_valid = 1'b0;
        chk("b2b_outputs", out_cnt, 64);
        chk("b2b_done_cnt", done_cnt, 1);
    endtask

    initial begin
        red_first = 1'b0;
        stall_prev = 1'b0;
        red_y = '0;
        exp_total = 0;
        clear_stats();
        test_reset();
        test_single_block();
        test_back_pressure();
        test_random();
        test_zero_blocks();
        test_reset_midframe();
        test_start_during_run();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
